// File: rtl/bcd_pkg.sv
// Shared constants and elaboration-time helpers for the binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_NIBBLE_W = 4;

    // Number of decimal digits needed to print 2^bin_w - 1.
    function automatic int bcd_digits_needed(input int bin_w);
        longint unsigned max_val;
        int              n;
        max_val = (64'd1 << bin_w) - 64'd1;
        n       = 1;
        while (max_val >= 64'd10) begin
            max_val = max_val / 64'd10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// One double-dabble correction cell: a digit of 5 or more gets 3 added so the
// following left shift carries into the next decimal digit.
module bcd_add3_cell
    import bcd_pkg::*;
(
    input  logic [BCD_NIBBLE_W-1:0] nibble,
    output logic [BCD_NIBBLE_W-1:0] adjusted
);

    always_comb begin
        adjusted = nibble;
        if (nibble >= 4'd5) begin
            adjusted = nibble + 4'd3;
        end
    end

endmodule

// File: rtl/binary_to_bcd.sv
// Unsigned binary to packed BCD: combinational double-dabble array followed by
// a single output register with a valid flag.
module binary_to_bcd
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 4,
    parameter int DIGITS = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [BIN_W-1:0]               binary,
    output logic                           out_valid,
    output logic [BCD_NIBBLE_W*DIGITS-1:0] bcd
);

    localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
    localparam int SW    = BIN_W + BCD_W;

    if (BIN_W < 1 || DIGITS < bcd_digits_needed(BIN_W)) begin : g_param_check
        $fatal(1, "binary_to_bcd: DIGITS too small to hold 2^BIN_W-1");
    end

    logic [SW-1:0]    start;
    logic [BCD_W-1:0] converted;
    logic             unused_low;

    assign start = {{BCD_W{1'b0}}, binary};

    // One stage per input bit: correct every digit, then shift the scratch left.
    for (genvar i = 0; i < BIN_W; i++) begin : g_iter
        logic [SW-1:0] s_in;
        logic [SW-1:0] adj;
        logic [SW-1:0] s_out;

        if (i == 0) begin : g_first
            assign s_in = start;
        end else begin : g_next
            assign s_in = g_iter[i-1].s_out;
        end

        assign adj[BIN_W-1:0] = s_in[BIN_W-1:0];

        for (genvar d = 0; d < DIGITS; d++) begin : g_digit
            bcd_add3_cell u_cell (
                .nibble  (s_in[BIN_W + BCD_NIBBLE_W*d +: BCD_NIBBLE_W]),
                .adjusted(adj [BIN_W + BCD_NIBBLE_W*d +: BCD_NIBBLE_W])
            );
        end

        assign s_out = adj << 1;
    end

    assign converted  = g_iter[BIN_W-1].s_out[SW-1:BIN_W];
    // After BIN_W shifts the binary field is all zeros.
    assign unused_low = ^g_iter[BIN_W-1].s_out[BIN_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                bcd <= converted;
            end
        end
    end

endmodule

// File: tb/tb_binary_to_bcd.sv
// Self-checking bench for binary_to_bcd: default 4-bit/2-digit instance plus an
// 8-bit/3-digit instance, checked against an arithmetic divide/modulo model.
module tb_binary_to_bcd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  binary = '0;
    logic        out_valid;
    logic [7:0]  bcd;

    logic        in_valid8 = 1'b0;
    logic [7:0]  binary8 = '0;
    logic        out_valid8;
    logic [11:0] bcd8;

    int checks = 0;
    int errors = 0;

    logic [7:0]  q4[$];
    logic [11:0] q8[$];

    always #5 clk = ~clk;

    binary_to_bcd u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .binary   (binary),
        .out_valid(out_valid),
        .bcd      (bcd)
    );

    binary_to_bcd #(.BIN_W(8), .DIGITS(3)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid8),
        .binary   (binary8),
        .out_valid(out_valid8),
        .bcd      (bcd8)
    );

    function automatic logic [7:0] ref4(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [11:0] ref12(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // Drive one cycle on the 4-bit instance; result is sampled 1 ns after the edge.
    task automatic drive4(input logic v, input logic [3:0] b);
        @(negedge clk);
        in_valid = v;
        binary   = b;
        if (v) q4.push_back(ref4(int'(b)));
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic v, input logic [7:0] b);
        @(negedge clk);
        in_valid8 = v;
        binary8   = b;
        if (v) q8.push_back(ref12(int'(b)));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        binary   = 4'd9;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bcd !== 8'h00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: bcd=%h out_valid=%b expected bcd=00 out_valid=0", bcd, out_valid);
        end
        checks++;
        if (bcd8 !== 12'h000 || out_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold8: bcd=%h out_valid=%b expected bcd=000 out_valid=0", bcd8, out_valid8);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_sequence();
        logic [7:0] exp;
        for (int n = 0; n < 4; n++) begin
            drive4(1'b1, 4'(n));
            exp = q4.pop_front();
            checks++;
            if (bcd !== exp || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_%0d: bcd=%h out_valid=%b expected bcd=%h out_valid=1", n, bcd, out_valid, exp);
            end
        end
    endtask

    task automatic test_over_nine();
        logic [7:0] exp;
        logic [3:0] vals [2];
        logic [7:0] lits [2];
        vals[0] = 4'b1010; lits[0] = 8'h10;
        vals[1] = 4'b1111; lits[1] = 8'h15;
        for (int k = 0; k < 2; k++) begin
            drive4(1'b1, vals[k]);
            exp = q4.pop_front();
            checks++;
            if (bcd !== exp || bcd !== lits[k] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL over_nine_%0d: bcd=%h out_valid=%b expected bcd=%h out_valid=1", vals[k], bcd, out_valid, lits[k]);
            end
        end
    endtask

    task automatic test_hold();
        logic [7:0] exp;
        drive4(1'b1, 4'd7);
        exp = q4.pop_front();
        checks++;
        if (bcd !== exp || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_load: bcd=%h out_valid=%b expected bcd=%h out_valid=1", bcd, out_valid, exp);
        end
        drive4(1'b0, 4'bxxxx);
        checks++;
        if (bcd !== 8'h07 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle: bcd=%h out_valid=%b expected bcd=07 out_valid=0", bcd, out_valid);
        end
        drive4(1'b0, 4'd3);
        checks++;
        if (bcd !== 8'h07 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle2: bcd=%h out_valid=%b expected bcd=07 out_valid=0", bcd, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int n = 0; n < 16; n++) begin
            drive4(1'b1, 4'(n));
            exp = q4.pop_front();
            checks++;
            if (bcd !== exp || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d: bcd=%h out_valid=%b expected bcd=%h out_valid=1", n, bcd, out_valid, exp);
            end
            checks++;
            if (bcd[3:0] > 4'd9 || bcd[7:4] > 4'd9) begin
                errors++;
                $display("FAIL b2b_nibble_%0d: bcd=%h expected every nibble <= 9", n, bcd);
            end
        end
    endtask

    task automatic test_wide();
        logic [11:0] exp;
        logic [7:0]  vals [5];
        logic [11:0] lits [5];
        vals[0] = 8'd255; lits[0] = 12'h255;
        vals[1] = 8'd100; lits[1] = 12'h100;
        vals[2] = 8'd99;  lits[2] = 12'h099;
        vals[3] = 8'd0;   lits[3] = 12'h000;
        vals[4] = 8'd58;  lits[4] = 12'h058;
        for (int k = 0; k < 5; k++) begin
            drive8(1'b1, vals[k]);
            exp = q8.pop_front();
            checks++;
            if (bcd8 !== exp || bcd8 !== lits[k] || out_valid8 !== 1'b1) begin
                errors++;
                $display("FAIL wide_%0d: bcd=%h out_valid=%b expected bcd=%h out_valid=1", vals[k], bcd8, out_valid8, lits[k]);
            end
        end
        for (int k = 0; k < 12; k++) begin
            int n;
            n = int'($urandom_range(255, 0));
            drive8(1'b1, 8'(n));
            exp = q8.pop_front();
            checks++;
            if (bcd8 !== exp || out_valid8 !== 1'b1) begin
                errors++;
                $display("FAIL wide_rand_%0d: bcd=%h out_valid=%b expected bcd=%h", n, bcd8, out_valid8, exp);
            end
        end
        drive8(1'b0, 8'd0);
    endtask

    task automatic test_async_reset();
        logic [7:0] exp;
        drive4(1'b1, 4'd13);
        exp = q4.pop_front();
        checks++;
        if (bcd !== exp || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_preload: bcd=%h out_valid=%b expected bcd=%h out_valid=1", bcd, out_valid, exp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bcd !== 8'h00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: bcd=%h out_valid=%b expected bcd=00 out_valid=0", bcd, out_valid);
        end
        q4.delete();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        drive4(1'b1, 4'd12);
        exp = q4.pop_front();
        checks++;
        if (bcd !== exp || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: bcd=%h out_valid=%b expected bcd=%h out_valid=1", bcd, out_valid, exp);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_over_nine();
        test_hold();
        test_back_to_back();
        test_wide();
        test_async_reset();
        drive4(1'b0, 4'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
